// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_pkg
// Description : Shared constants for the edge-capturing PIO: register word
//               addresses and edge-capture mode encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package pio_pkg;

    // Register word addresses; 6 and 7 are unmapped
    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_INPUT = 3'd1;
    localparam logic [2:0] ADDR_MASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGE  = 3'd3;
    localparam logic [2:0] ADDR_SET   = 3'd4;
    localparam logic [2:0] ADDR_CLR   = 3'd5;

    // Edge-capture modes
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage
`default_nettype wire

// File: rtl/pio_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pio_sync_edge
// Description : Input synchroniser, one-cycle delayed copy, per-bit edge
//               detector and post-reset arming counter.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous reset, active-high
//   async_i      in   WIDTH asynchronous inputs
//   sync_o       out  WIDTH synchronised inputs (last chain stage)
//   edge_pulse_o out  WIDTH one-cycle edge pulses, suppressed until armed
// ============================================================================
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] edge_pulse_o
);

    // The chain and prev flop hold zero through reset, so the first real
    // sample would look like a transition from 0. Capture stays disabled
    // until the chain and prev flop both hold genuine samples.
    localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_d;
    logic [WIDTH-1:0]                  prev_q;
    logic [2:0]                        arm_cnt_q;
    logic [2:0]                        arm_cnt_d;
    logic                              armed;
    logic [WIDTH-1:0]                  sync;
    logic [WIDTH-1:0]                  edge_raw;

    assign sync  = chain_q[SYNC_STAGES-1];
    assign armed = (arm_cnt_q == ARM_DONE);

    always_comb begin
        chain_d   = {chain_q[SYNC_STAGES-2:0], async_i};
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q   <= '0;
            prev_q    <= '0;
            arm_cnt_q <= '0;
        end else begin
            chain_q   <= chain_d;
            prev_q    <= sync;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
        assign edge_raw = ~sync & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
        assign edge_raw = sync ^ prev_q;
    end else begin : g_rise
        assign edge_raw = sync & ~prev_q;
    end

    assign sync_o       = sync;
    assign edge_pulse_o = armed ? edge_raw : '0;

endmodule
`default_nettype wire

// File: rtl/pio_edge_irq.sv
`default_nettype none
// ============================================================================
// Module      : pio_edge_irq
// Description : Avalon-MM PIO slave with WIDTH-bit output register (with
//               atomic set/clear), synchronised input port, per-bit edge
//               capture, interrupt mask and registered level interrupt.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous reset, active-high
//   address    in   3-bit register word select
//   chipselect in   slave select
//   write_n    in   write strobe, active-low
//   read_n     in   read strobe, active-low
//   writedata  in   32-bit write data, low WIDTH bits used
//   readdata   out  32-bit read data, one cycle latency, zero-extended
//   in_port    in   WIDTH asynchronous inputs
//   out_port   out  WIDTH output register contents
//   irq        out  level interrupt, active-high
// ============================================================================
module pio_edge_irq
    import pio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0000_00A5,
    parameter int          EDGE_TYPE   = EDGE_RISE,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] wd;
    logic [31:0]      unused_writedata;

    logic [WIDTH-1:0] out_q,      out_d;
    logic [WIDTH-1:0] mask_q,     mask_d;
    logic [WIDTH-1:0] edgecap_q,  edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q,      irq_d;
    logic [31:0]      rd_val;

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] edge_pulse;

    assign wr               = chipselect & ~write_n;
    assign rd               = chipselect & ~read_n;
    assign wd               = writedata[WIDTH-1:0];
    // Bits above WIDTH are deliberately ignored
    assign unused_writedata = writedata;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk          (clk),
        .reset        (reset),
        .async_i      (in_port),
        .sync_o       (sync),
        .edge_pulse_o (edge_pulse)
    );

    always_comb begin
        out_d     = out_q;
        mask_d    = mask_q;
        edgecap_d = edgecap_q;

        if (wr) begin
            case (address)
                ADDR_DATA: out_d     = wd;
                ADDR_MASK: mask_d    = wd;
                ADDR_EDGE: edgecap_d = edgecap_q & ~wd;
                ADDR_SET:  out_d     = out_q | wd;
                ADDR_CLR:  out_d     = out_q & ~wd;
                default:   ;
            endcase
        end

        // Applied after the clear so a coincident edge keeps its bit set
        edgecap_d = edgecap_d | edge_pulse;

        irq_d = |(edgecap_q & mask_q);

        rd_val = '0;
        case (address)
            ADDR_DATA:  rd_val[WIDTH-1:0] = out_q;
            ADDR_INPUT: rd_val[WIDTH-1:0] = sync;
            ADDR_MASK:  rd_val[WIDTH-1:0] = mask_q;
            ADDR_EDGE:  rd_val[WIDTH-1:0] = edgecap_q;
            default:    rd_val            = '0;
        endcase

        readdata_d = rd ? rd_val : readdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= RESET_VALUE[WIDTH-1:0];
            mask_q     <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign out_port = out_q;
    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_pio_edge_irq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_edge_irq
// Description : Self-checking bench for pio_edge_irq. Three instances share
//               one bus and one input vector: 8-bit rising, 32-bit any-edge,
//               5-bit falling with a deeper synchroniser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_edge_irq;
    import pio_pkg::*;

    localparam int NDUT = 3;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [2:0]  address    = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic        read_n     = 1'b1;
    logic [31:0] writedata  = 32'd0;
    logic [31:0] in_bus     = 32'd0;

    logic [31:0] rd0, rd1, rd2;
    logic [7:0]  out0;
    logic [31:0] out1;
    logic [4:0]  out2;
    logic        irq0, irq1, irq2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_edge_irq #(.WIDTH(8), .RESET_VALUE(32'h0000_00A5), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd0),
        .in_port(in_bus[7:0]), .out_port(out0), .irq(irq0));

    pio_edge_irq #(.WIDTH(32), .RESET_VALUE(32'h0000_00A5), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd1),
        .in_port(in_bus), .out_port(out1), .irq(irq1));

    pio_edge_irq #(.WIDTH(5), .RESET_VALUE(32'h0000_01F3), .EDGE_TYPE(1), .SYNC_STAGES(3)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd2),
        .in_port(in_bus[4:0]), .out_port(out2), .irq(irq2));

    // ---------------- reference model ----------------
    function automatic logic [31:0] wmask(input int d);
        case (d)
            0:       return 32'h0000_00FF;
            1:       return 32'hFFFF_FFFF;
            default: return 32'h0000_001F;
        endcase
    endfunction

    function automatic int etype(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int nsync(input int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic logic [31:0] rstval(input int d);
        return (d == 2) ? 32'h0000_01F3 : 32'h0000_00A5;
    endfunction

    logic [31:0] m_out  [NDUT];
    logic [31:0] m_mask [NDUT];
    logic [31:0] m_ecap [NDUT];
    logic [31:0] m_rd   [NDUT];
    logic        m_irq  [NDUT];
    // samp[k] = in_bus value seen at the k-th clock edge after reset released
    logic [31:0] samp   [0:4095];
    int          k = 0;

    task automatic model_edge();
        logic [31:0] wm, a, b, ev, wdm;
        logic        new_irq;
        int          j, n;
        if (reset) begin
            k = 0;
            for (int d = 0; d < NDUT; d++) begin
                m_out[d]  = rstval(d) & wmask(d);
                m_mask[d] = 32'd0;
                m_ecap[d] = 32'd0;
                m_rd[d]   = 32'd0;
                m_irq[d]  = 1'b0;
            end
        end else begin
            k = k + 1;
            samp[k] = in_bus;
            for (int d = 0; d < NDUT; d++) begin
                wm = wmask(d);
                n  = nsync(d);
                if (chipselect && !read_n) begin
                    case (address)
                        3'd0:    m_rd[d] = m_out[d];
                        3'd1:    m_rd[d] = (k - n >= 1) ? (samp[k-n] & wm) : 32'd0;
                        3'd2:    m_rd[d] = m_mask[d];
                        3'd3:    m_rd[d] = m_ecap[d];
                        default: m_rd[d] = 32'd0;
                    endcase
                end
                // A change between samples j-1 and j is logged n edges later;
                // the first sample after reset is never treated as a change.
                ev = 32'd0;
                j  = k - n;
                if (j >= 2) begin
                    a = samp[j-1] & wm;
                    b = samp[j] & wm;
                    case (etype(d))
                        0:       ev = b & ~a;
                        1:       ev = a & ~b;
                        default: ev = a ^ b;
                    endcase
                end
                new_irq = |(m_ecap[d] & m_mask[d]);
                wdm = writedata & wm;
                if (chipselect && !write_n) begin
                    case (address)
                        3'd0:    m_out[d]  = wdm;
                        3'd2:    m_mask[d] = wdm;
                        3'd3:    m_ecap[d] = m_ecap[d] & ~wdm;
                        3'd4:    m_out[d]  = m_out[d] | wdm;
                        3'd5:    m_out[d]  = m_out[d] & ~wdm;
                        default: ;
                    endcase
                end
                m_ecap[d] = m_ecap[d] | ev;
                m_irq[d]  = new_irq;
            end
        end
    endtask

    // ---------------- checking ----------------
    function automatic logic [31:0] obs_out(input int d);
        case (d)
            0:       return {24'd0, out0};
            1:       return out1;
            default: return {27'd0, out2};
        endcase
    endfunction

    function automatic logic obs_irq(input int d);
        case (d)
            0:       return irq0;
            1:       return irq1;
            default: return irq2;
        endcase
    endfunction

    function automatic logic [31:0] obs_rd(input int d);
        case (d)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("out_port[%0d] k=%0d", d, k), obs_out(d), m_out[d]);
            chk($sformatf("irq[%0d] k=%0d", d, k), {31'd0, obs_irq(d)}, {31'd0, m_irq[d]});
            chk($sformatf("readdata[%0d] k=%0d", d, k), obs_rd(d), m_rd[d]);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] data);
        chipselect = 1'b1;
        write_n    = 1'b0;
        read_n     = 1'b1;
        address    = a;
        writedata  = data;
        step();
        bus_idle();
    endtask

    task automatic bus_read(input logic [2:0] a);
        chipselect = 1'b1;
        write_n    = 1'b1;
        read_n     = 1'b0;
        address    = a;
        step();
        bus_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Input held high through reset and arming: no false edge
        in_bus = 32'h0000_0001;
        reset  = 1'b1;
        steps(2);
        reset  = 1'b0;
        chk("reset out_port", {24'd0, out0}, 32'h0000_00A5);
        chk("reset irq", {31'd0, irq0}, 32'd0);
        chk("reset out_port w5", {27'd0, out2}, 32'h0000_0013);
        bus_read(ADDR_DATA);
        chk("read DATA after reset", rd0, 32'h0000_00A5);
        steps(3);
        bus_read(ADDR_EDGE);
        chk("no false edge", rd0, 32'd0);

        // Output register: full write, atomic set and clear
        bus_write(ADDR_DATA, 32'hFFFF_FF3C);
        chk("DATA write", {24'd0, out0}, 32'h0000_003C);
        bus_write(ADDR_SET, 32'h0000_0081);
        chk("OUTSET", {24'd0, out0}, 32'h0000_00BD);
        bus_write(ADDR_CLR, 32'h0000_000C);
        chk("OUTCLR", {24'd0, out0}, 32'h0000_00B1);
        bus_read(ADDR_SET);
        chk("OUTSET reads 0", rd0, 32'd0);

        // Rising edge on bit 2
        in_bus = 32'h0000_0005;
        steps(3);
        bus_read(ADDR_EDGE);
        chk("EDGECAP rise bit2", rd0, 32'h0000_0004);
        bus_read(ADDR_INPUT);
        chk("INPUT value", rd0, 32'h0000_0005);

        // Mask -> irq next cycle; clear -> irq drops one cycle later
        bus_write(ADDR_MASK, 32'h0000_0004);
        step();
        chk("irq after mask", {31'd0, irq0}, 32'd1);
        bus_write(ADDR_EDGE, 32'h0000_0004);
        chk("irq still set on clear edge", {31'd0, irq0}, 32'd1);
        step();
        chk("irq after clear", {31'd0, irq0}, 32'd0);

        // Re-capture, then coincident edge and clear: edge wins
        in_bus = 32'h0000_0001;
        steps(4);
        in_bus = 32'h0000_0005;
        steps(4);
        chk("irq re-armed", {31'd0, irq0}, 32'd1);
        in_bus = 32'h0000_0001;
        steps(4);
        in_bus = 32'h0000_0005;
        steps(2);
        bus_write(ADDR_EDGE, 32'h0000_0004);
        step();
        chk("irq edge beats clear", {31'd0, irq0}, 32'd1);
        bus_read(ADDR_EDGE);
        chk("EDGECAP edge beats clear", rd0, 32'h0000_0004);

        // 32-bit any-edge instance: bit 31 on both edges
        bus_write(ADDR_EDGE, 32'hFFFF_FFFF);
        in_bus = in_bus | 32'h8000_0000;
        steps(3);
        bus_read(ADDR_EDGE);
        chk("w32 bit31 rise", {31'd0, rd1[31]}, 32'd1);
        bus_write(ADDR_EDGE, 32'h8000_0000);
        in_bus = in_bus & 32'h7FFF_FFFF;
        steps(3);
        bus_read(ADDR_EDGE);
        chk("w32 bit31 fall", {31'd0, rd1[31]}, 32'd1);
        bus_read(3'd6);
        chk("addr 6 reads 0", rd1, 32'd0);
        bus_read(3'd7);
        chk("addr 7 reads 0", rd1, 32'd0);

        // Randomised traffic against the model, with occasional resets
        for (int c = 0; c < 1500; c++) begin
            reset      = ($urandom_range(0, 299) == 0);
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = $urandom_range(0, 1) != 0;
            read_n     = $urandom_range(0, 1) != 0;
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 3) != 0)
                    in_bus = in_bus ^ (32'd1 << $urandom_range(0, 7));
                else
                    in_bus = in_bus ^ (32'd1 << $urandom_range(0, 31));
            end
            step();
        end
        reset = 1'b0;
        bus_idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
